demux4_dist: RTL
================

DEMUX4_DIST -- requirements
Module: demux4_dist

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the data width of the input and of every output lane.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port in_valid, input, 1 bit: the source offers a word.
REQ-005 Port in_ready, output, 1 bit: the block accepts the offered word this cycle.
REQ-006 Port in_select, input, 2 bits: destination lane index (0..3) of the offered word.
REQ-007 Port in_data, input, W bits: the offered word.
REQ-008 Ports out_valid_0..out_valid_3, output, 1 bit each: the lane holding register is full.
REQ-009 Ports out_ready_0..out_ready_3, input, 1 bit each: the lane consumer takes the held word.
REQ-010 Ports out_data_0..out_data_3, output, W bits each: the lane holding register contents.
REQ-011 Port drop_count, output, 8 bits: count of cycles with in_valid=1 and in_ready=0 (back-pressure stalls).

Function
REQ-012 Each lane SHALL be a two-state machine, EMPTY or FULL; out_valid_n SHALL be 1 exactly when lane n is FULL.
REQ-013 in_ready SHALL be combinational: it equals 1 when lane[in_select] is EMPTY, or is FULL with out_ready[in_select]=1; otherwise it equals 0.
REQ-014 An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_data is captured into lane[in_select] and that lane becomes or stays FULL.
REQ-015 An output transfer on lane n SHALL occur on a rising edge where out_valid_n=1 and out_ready_n=1; the lane becomes EMPTY unless the same edge carries an input transfer to lane n.
REQ-016 Simultaneous input and output transfer on the same lane SHALL replace the data, keep the lane FULL and lose no word (full-throughput pass-through).
REQ-017 Output transfers on lanes other than in_select SHALL proceed independently in the same cycle.
REQ-018 Latency SHALL be one cycle: a word accepted at edge k appears on out_data_n with out_valid_n=1 after edge k.
REQ-019 out_data_n SHALL remain stable while lane n is FULL and out_ready_n=0.
REQ-020 in_ready SHALL NOT depend on in_valid.
REQ-021 out_data_n SHALL be don't-care while lane n is EMPTY but SHALL hold its last value; it is not cleared.
REQ-022 drop_count SHALL increment by 1 on each cycle with in_valid=1 and in_ready=0, and SHALL saturate at 255 with no wrap.
REQ-023 in_select values are always 0..3 (full decode); no illegal encoding exists.

Reset
REQ-024 While rst_n=0, all lanes SHALL be EMPTY, all out_valid_n SHALL be 0, every out_data_n SHALL be 0 and drop_count SHALL be 0, independent of clk.
REQ-025 Assertion of rst_n mid-transfer SHALL discard all held words, with no partial or late output after release.
REQ-026 The first transfer after release SHALL be possible on the first rising edge with rst_n=1.

Structure
REQ-027 The shared package SHALL hold the lane count constant (4), the lane index width (2), the drop counter width (8) and the lane-state enumeration {EMPTY, FULL}.
REQ-028 One sub-module, demux_lane, SHALL implement one lane's holding register and state; it SHALL be instantiated four times.
REQ-029 The top level SHALL contain only the select decode, the in_ready mux and drop_count.

Verification
REQ-030 Reset then in_valid=1, in_select=2, in_data=0xA5 for one cycle -> next cycle out_valid_2=1, out_data_2=0xA5, other lanes valid=0, drop_count=0.
REQ-031 Lane 1 FULL (0x11) with out_ready_1=0, then offer 0x22 to lane 1 for 3 cycles -> in_ready=0, out_data_1 stays 0x11, drop_count=3.
REQ-032 Lane 0 FULL (0x01), out_ready_0=1 and in_valid=1, in_select=0, in_data=0x02 in the same cycle -> in_ready=1, lane 0 still FULL with out_data_0=0x02, exactly one word consumed.
REQ-033 Stream 0x10,0x20,0x30,0x40 to lanes 0..3 on consecutive cycles with all out_ready=0 -> all four out_valid=1 holding those values, no stall.
REQ-034 Hold in_valid=1 to a blocked lane for 300 cycles -> drop_count reaches 255 and stays 255.
REQ-035 rst_n pulsed low mid-cycle while lanes 0 and 3 are FULL -> out_valid_0 and out_valid_3 drop immediately without a clock edge, out_data=0 and drop_count=0.

Source files
------------

// File: rtl/demux4_dist_pkg.sv
// Shared constants and lane-state type for the four-lane distributing demux.
package demux4_dist_pkg;

  localparam int LANES  = 4;
  localparam int SEL_W  = 2;
  localparam int DROP_W = 8;

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_e;

endpackage

// File: rtl/demux_lane.sv
// One output lane: a single-word holding register with EMPTY/FULL state.
//
//   state | meaning
//   ------+---------------------------------------------
//   EMPTY | no word held, out_valid_o low
//   FULL  | word held on out_data_o, waiting for consumer
module demux_lane
  import demux4_dist_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         out_ready_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o
);

  lane_state_e  state_q, state_d;
  logic [W-1:0] data_q, data_d;

  // A write wins over a drain on the same edge, giving pass-through at full rate.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (wr_en_i) begin
      state_d = FULL;
      data_d  = wr_data_i;
    end else if (state_q == FULL && out_ready_i) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = (state_q == FULL);
  assign out_data_o  = data_q;

endmodule

// File: rtl/demux4_dist.sv
// Four-lane demultiplexer: steers each accepted word into the selected lane
// holding register and counts back-pressure stalls (saturating).
module demux4_dist
  import demux4_dist_pkg::*;
#(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_select,
  input  logic [W-1:0]      in_data,
  output logic              out_valid_0,
  output logic              out_valid_1,
  output logic              out_valid_2,
  output logic              out_valid_3,
  input  logic              out_ready_0,
  input  logic              out_ready_1,
  input  logic              out_ready_2,
  input  logic              out_ready_3,
  output logic [W-1:0]      out_data_0,
  output logic [W-1:0]      out_data_1,
  output logic [W-1:0]      out_data_2,
  output logic [W-1:0]      out_data_3,
  output logic [DROP_W-1:0] drop_count
);

  logic [LANES-1:0] lane_ready;
  logic [LANES-1:0] lane_valid;
  logic [LANES-1:0] lane_wr;
  logic [W-1:0]     lane_data [LANES];
  logic [DROP_W-1:0] drop_q, drop_d;

  assign lane_ready = {out_ready_3, out_ready_2, out_ready_1, out_ready_0};

  // Independent of in_valid so the source may wait on it before offering.
  assign in_ready = !lane_valid[in_select] || lane_ready[in_select];

  always_comb begin
    lane_wr = '0;
    lane_wr[in_select] = in_valid && in_ready;
  end

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    demux_lane #(.W(W)) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en_i     (lane_wr[n]),
      .wr_data_i   (in_data),
      .out_ready_i (lane_ready[n]),
      .out_valid_o (lane_valid[n]),
      .out_data_o  (lane_data[n])
    );
  end

  always_comb begin
    drop_d = drop_q;
    if (in_valid && !in_ready && drop_q != DROP_MAX) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign drop_count  = drop_q;
  assign out_valid_0 = lane_valid[0];
  assign out_valid_1 = lane_valid[1];
  assign out_valid_2 = lane_valid[2];
  assign out_valid_3 = lane_valid[3];
  assign out_data_0  = lane_data[0];
  assign out_data_1  = lane_data[1];
  assign out_data_2  = lane_data[2];
  assign out_data_3  = lane_data[3];

endmodule
